// File: rtl/systolic_pe.sv
// Processing element for the systolic matrix-multiply array: a pipelined multiplier feeding
// either a weight-stationary partial-sum chain or a local output-stationary accumulator.
module systolic_pe #(
  parameter int IFMAP_BITWIDTH = 16,
  parameter int W_BITWIDTH     = 8,
  parameter int OFMAP_BITWIDTH = 32,  // must be >= IFMAP_BITWIDTH + W_BITWIDTH
  parameter int SIGNED         = 1,
  parameter int SATURATE       = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      mode,
  input  logic                      I_valid,
  input  logic [IFMAP_BITWIDTH-1:0] I_in,
  output logic                      I_valid_out,
  output logic [IFMAP_BITWIDTH-1:0] I_out,
  input  logic                      W_valid,
  input  logic [W_BITWIDTH-1:0]     W_in,
  output logic                      W_valid_out,
  output logic [W_BITWIDTH-1:0]     W_out,
  input  logic                      W_swap,
  input  logic                      P_valid_in,
  input  logic [OFMAP_BITWIDTH-1:0] P_in,
  output logic                      P_valid_out,
  output logic [OFMAP_BITWIDTH-1:0] P_out,
  input  logic                      acc_clear,
  input  logic                      drain,
  output logic                      ovf
);

  localparam int   PW  = IFMAP_BITWIDTH + W_BITWIDTH;
  localparam int   OW  = OFMAP_BITWIDTH;
  localparam logic SGN = (SIGNED != 0);
  localparam logic SAT = (SATURATE != 0);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ACC       = 2'd1;
  localparam logic [1:0] S_DRAIN_OWN = 2'd2;
  localparam logic [1:0] S_DRAIN_FWD = 2'd3;

  logic [W_BITWIDTH-1:0] w_shadow;
  logic [W_BITWIDTH-1:0] w_act;
  logic                  prod_v;
  logic [PW-1:0]         prod;
  logic [PW-1:0]         i_ext;
  logic [PW-1:0]         w_ext;
  logic [PW-1:0]         prod_calc;
  logic [OW-1:0]         acc;
  logic [OW:0]           prod_wide;
  logic [OW-1:0]         prod_ext;
  logic [OW:0]           ws_sum;
  logic [OW:0]           acc_sum;
  logic [1:0]            state;
  logic                  os_active;

  // Extends a product to OW+1 bits so the exact sum and its carry/sign fit.
  function automatic logic [OW:0] ext_p(input logic [PW-1:0] b);
    return {{(OW + 1 - PW){SGN & b[PW-1]}}, b};
  endfunction

  // Returns {overflow, result}: exact add, then clamp or wrap.
  function automatic logic [OW:0] sum_f(input logic [OW-1:0] a, input logic [PW-1:0] b);
    logic [OW:0]   s;
    logic          o;
    logic [OW-1:0] r;
    s = {SGN & a[OW-1], a} + ext_p(b);
    o = SGN ? (s[OW] != s[OW-1]) : s[OW];
    r = s[OW-1:0];
    if (SAT && o) begin
      if (!SGN)       r = '1;
      else if (s[OW]) r = {1'b1, {(OW - 1){1'b0}}};
      else            r = {1'b0, {(OW - 1){1'b1}}};
    end
    return {o, r};
  endfunction

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    i_ext     = {{W_BITWIDTH{SGN & I_in[IFMAP_BITWIDTH-1]}}, I_in};
    w_ext     = {{IFMAP_BITWIDTH{SGN & w_act[W_BITWIDTH-1]}}, w_act};
    prod_calc = i_ext * w_ext;
    prod_wide = ext_p(prod);
    prod_ext  = prod_wide[OW-1:0];
    ws_sum    = sum_f(P_in, prod);
    acc_sum   = sum_f(acc, prod);
    os_active = (state != S_IDLE) || mode;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values;
  // this is what lets a same-cycle W_valid + W_swap hand the old shadow to w_act.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      I_valid_out <= 1'b0;
      I_out       <= '0;
      W_valid_out <= 1'b0;
      W_out       <= '0;
      w_shadow    <= '0;
      w_act       <= '0;
      prod_v      <= 1'b0;
      prod        <= '0;
    end else begin
      I_valid_out <= I_valid;
      I_out       <= I_in;
      W_valid_out <= W_valid;
      W_out       <= W_in;
      if (W_valid) w_shadow <= W_in;
      if (W_swap)  w_act    <= w_shadow;
      prod_v <= I_valid;
      if (I_valid) prod <= prod_calc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      P_valid_out <= 1'b0;
      P_out       <= '0;
      acc         <= '0;
      ovf         <= 1'b0;
      state       <= S_IDLE;
    end else begin
      if (!os_active) begin
        // Weight-stationary: add the product into the partial sum arriving from the north.
        P_valid_out <= prod_v;
        if (prod_v) begin
          P_out <= ws_sum[OW-1:0];
          if (ws_sum[OW]) ovf <= 1'b1;
        end
      end else begin
        P_valid_out <= 1'b0;
        case (state)
          S_IDLE, S_ACC: begin
            if (prod_v) begin
              acc <= acc_sum[OW-1:0];
              if (acc_sum[OW]) ovf <= 1'b1;
            end
            if (drain)       state <= S_DRAIN_OWN;
            else if (prod_v) state <= S_ACC;
          end
          S_DRAIN_OWN: begin
            // A product landing during the drain starts the next accumulation.
            P_out       <= acc;
            P_valid_out <= 1'b1;
            acc         <= prod_v ? prod_ext : '0;
            state       <= S_DRAIN_FWD;
          end
          default: begin
            P_out       <= P_in;
            P_valid_out <= P_valid_in;
            if (prod_v) begin
              acc <= acc_sum[OW-1:0];
              if (acc_sum[OW]) ovf <= 1'b1;
            end
            if (!drain) state <= S_IDLE;
          end
        endcase
      end
      // NOTE: the last non-blocking assignment in a block wins, so acc_clear overrides the updates above.
      if (acc_clear) begin
        acc <= (os_active && prod_v) ? prod_ext : '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe: three parameter variants share one stimulus stream,
// checked by directed vectors and by an integer-arithmetic reference model under random stimulus.
module tb_systolic_pe;

  typedef enum logic [1:0] {PH_IDLE, PH_ACC, PH_OWN, PH_FWD} phase_e;

  typedef struct {
    logic [15:0] i_out;
    logic        i_v;
    logic [7:0]  w_out;
    logic        w_v;
    logic [7:0]  sh;
    logic [7:0]  act;
    logic        pv;
    longint      prod;
    longint      acc;
    logic        ovf;
    logic [31:0] p_out;
    logic        p_v;
    phase_e      ph;
  } mstate_t;

  typedef struct packed {
    logic [7:0]       w;
    logic [15:0]      i;
    logic [31:0]      p;
    logic [2:0][31:0] exp;  // [0] signed/sat, [1] signed/wrap, [2] unsigned/sat
    logic [2:0]       eo;
  } row_t;

  logic        clk = 1'b0;
  logic        rstn, mode, i_valid, w_valid, w_swap, p_valid_in, acc_clear, drain;
  logic [15:0] i_in;
  logic [7:0]  w_in;
  logic [31:0] p_in;

  logic [31:0] p_out_d [3];
  logic        p_v_d   [3];
  logic        ovf_d   [3];
  logic [15:0] i_out_d [3];
  logic        i_v_d   [3];
  logic [7:0]  w_out_d [3];
  logic        w_v_d   [3];

  mstate_t m [3];
  row_t    rows [7];
  int      n_checks = 0;
  int      n_errors = 0;

  always #5 clk = ~clk;

  systolic_pe #(.IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32), .SIGNED(1), .SATURATE(1)) u_dut (
    .clk(clk), .rstn(rstn), .mode(mode), .I_valid(i_valid), .I_in(i_in),
    .I_valid_out(i_v_d[0]), .I_out(i_out_d[0]), .W_valid(w_valid), .W_in(w_in),
    .W_valid_out(w_v_d[0]), .W_out(w_out_d[0]), .W_swap(w_swap), .P_valid_in(p_valid_in),
    .P_in(p_in), .P_valid_out(p_v_d[0]), .P_out(p_out_d[0]), .acc_clear(acc_clear),
    .drain(drain), .ovf(ovf_d[0]));

  systolic_pe #(.IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32), .SIGNED(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rstn(rstn), .mode(mode), .I_valid(i_valid), .I_in(i_in),
    .I_valid_out(i_v_d[1]), .I_out(i_out_d[1]), .W_valid(w_valid), .W_in(w_in),
    .W_valid_out(w_v_d[1]), .W_out(w_out_d[1]), .W_swap(w_swap), .P_valid_in(p_valid_in),
    .P_in(p_in), .P_valid_out(p_v_d[1]), .P_out(p_out_d[1]), .acc_clear(acc_clear),
    .drain(drain), .ovf(ovf_d[1]));

  systolic_pe #(.IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32), .SIGNED(0), .SATURATE(1)) u_uns (
    .clk(clk), .rstn(rstn), .mode(mode), .I_valid(i_valid), .I_in(i_in),
    .I_valid_out(i_v_d[2]), .I_out(i_out_d[2]), .W_valid(w_valid), .W_in(w_in),
    .W_valid_out(w_v_d[2]), .W_out(w_out_d[2]), .W_swap(w_swap), .P_valid_in(p_valid_in),
    .P_in(p_in), .P_valid_out(p_v_d[2]), .P_out(p_out_d[2]), .acc_clear(acc_clear),
    .drain(drain), .ovf(ovf_d[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Numeric value of the low w bits of v, as two's complement or plain binary.
  function automatic longint xv(input logic [31:0] v, input int w, input bit sg);
    longint r;
    r = longint'(v) & ((longint'(1) << w) - 1);
    if (sg && v[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic longint msum(input longint a, input longint b, input bit sg, input bit st,
                                  output bit o);
    longint lo, hi, s;
    lo = sg ? -(longint'(1) << 31) : 0;
    hi = sg ? (longint'(1) << 31) - 1 : (longint'(1) << 32) - 1;
    s  = a + b;
    o  = (s < lo) || (s > hi);
    if (!o) return s;
    if (st) return (s > hi) ? hi : lo;
    return xv(32'(s), 32, sg);
  endfunction

  function automatic mstate_t mzero();
    mstate_t z;
    z.i_out = '0; z.i_v = 1'b0; z.w_out = '0; z.w_v = 1'b0; z.sh = '0; z.act = '0;
    z.pv = 1'b0; z.prod = 0; z.acc = 0; z.ovf = 1'b0; z.p_out = '0; z.p_v = 1'b0; z.ph = PH_IDLE;
    return z;
  endfunction

  function automatic mstate_t mstep(input mstate_t c, input bit sg, input bit st);
    mstate_t n;
    bit      o, os;
    longint  s;
    n = c;
    n.i_out = i_in; n.i_v = i_valid; n.w_out = w_in; n.w_v = w_valid;
    if (w_valid) n.sh = w_in;
    if (w_swap)  n.act = c.sh;
    n.pv = i_valid;
    if (i_valid) n.prod = xv(32'(i_in), 16, sg) * xv(32'(c.act), 8, sg);
    os = (c.ph != PH_IDLE) || mode;
    if (!os) begin
      n.p_v = c.pv;
      if (c.pv) begin
        s = msum(xv(p_in, 32, sg), c.prod, sg, st, o);
        n.p_out = 32'(s);
        if (o) n.ovf = 1'b1;
      end
    end else begin
      n.p_v = 1'b0;
      if (c.ph == PH_OWN) begin
        n.p_out = 32'(c.acc);
        n.p_v   = 1'b1;
        n.acc   = c.pv ? c.prod : 0;
        n.ph    = PH_FWD;
      end else begin
        if (c.pv) begin
          n.acc = msum(c.acc, c.prod, sg, st, o);
          if (o) n.ovf = 1'b1;
        end
        if (c.ph == PH_FWD) begin
          n.p_out = p_in;
          n.p_v   = p_valid_in;
          if (!drain) n.ph = PH_IDLE;
        end else if (drain) n.ph = PH_OWN;
        else if (c.pv)      n.ph = PH_ACC;
      end
    end
    if (acc_clear) begin
      n.acc = (os && c.pv) ? c.prod : 0;
      n.ovf = 1'b0;
    end
    if (!rstn) n = mzero();
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) m[k] = mstep(m[k], k != 2, k != 1);
    #1;
  endtask

  task automatic cmp_model(input int k);
    check($sformatf("rand p_out dut%0d", k), p_out_d[k], m[k].p_out);
    check($sformatf("rand p_valid dut%0d", k), p_v_d[k], m[k].p_v);
    check($sformatf("rand ovf dut%0d", k), ovf_d[k], m[k].ovf);
    check($sformatf("rand i_fwd dut%0d", k), {i_v_d[k], i_out_d[k]}, {m[k].i_v, m[k].i_out});
    check($sformatf("rand w_fwd dut%0d", k), {w_v_d[k], w_out_d[k]}, {m[k].w_v, m[k].w_out});
  endtask

  task automatic idle_inputs();
    mode = 1'b0; i_valid = 1'b0; i_in = '0; w_valid = 1'b0; w_in = '0; w_swap = 1'b0;
    p_valid_in = 1'b0; p_in = '0; acc_clear = 1'b0; drain = 1'b0;
  endtask

  task automatic apply_row(input int r);
    w_valid = 1'b1; w_in = rows[r].w; acc_clear = 1'b1; tick();
    w_valid = 1'b0; acc_clear = 1'b0; w_swap = 1'b1; tick();
    w_swap = 1'b0; i_valid = 1'b1; i_in = rows[r].i; tick();
    check($sformatf("row%0d p_valid one cycle after I_valid", r), p_v_d[0], 1'b0);
    i_valid = 1'b0; p_in = rows[r].p; tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("row%0d p_out dut%0d", r, k), p_out_d[k], rows[r].exp[k]);
      check($sformatf("row%0d p_valid dut%0d", r, k), p_v_d[k], 1'b1);
      check($sformatf("row%0d ovf dut%0d", r, k), ovf_d[k], rows[r].eo[k]);
    end
  endtask

  initial begin
    //                w       i         p             uns/sat        signed/wrap    signed/sat     ovf
    rows[0] = '{8'hFD, 16'd1000, 32'd7,         {32'd253007,    32'hFFFFF44F, 32'hFFFFF44F}, 3'b000};
    rows[1] = '{8'd10, 16'd10,   32'h7FFFFFF0,  {32'h80000054,  32'h80000054, 32'h7FFFFFFF}, 3'b011};
    rows[2] = '{8'hFF, 16'hFFFF, 32'd0,         {32'h00FEFF01,  32'd1,        32'd1},        3'b000};
    rows[3] = '{8'h80, 16'h7FFF, 32'h80000000,  {32'h803FFF80,  32'h7FC00080, 32'h80000000}, 3'b011};
    rows[4] = '{8'hFF, 16'hFFFF, 32'hFFFFFFFF,  {32'hFFFFFFFF,  32'd0,        32'd0},        3'b100};
    rows[5] = '{8'd0,  16'd1234, 32'd42,        {32'd42,        32'd42,       32'd42},       3'b000};
    rows[6] = '{8'h85, 16'h8000, 32'hFFFFFFFF,  {32'hFFFFFFFF,  32'h003D7FFF, 32'h003D7FFF}, 3'b100};

    for (int k = 0; k < 3; k++) m[k] = mzero();
    idle_inputs();
    rstn = 1'b0;
    tick(); tick();
    check("reset p_out", p_out_d[0], 32'd0);
    check("reset valids", {p_v_d[0], i_v_d[0], w_v_d[0]}, 3'b000);
    check("reset fwd data", {i_out_d[0], w_out_d[0]}, 24'd0);
    check("reset ovf", ovf_d[0], 1'b0);
    rstn = 1'b1;
    tick();

    for (int r = 0; r < 7; r++) apply_row(r);

    // Double buffer: shadow 2, then load 5 and swap together.
    w_valid = 1'b1; w_in = 8'd2; tick();
    w_in = 8'd5; w_swap = 1'b1; tick();
    w_valid = 1'b0; w_swap = 1'b0; i_valid = 1'b1; i_in = 16'd10; tick();
    i_valid = 1'b0; p_in = 32'd0; tick();
    check("dbuf old shadow", p_out_d[0], 32'd20);
    w_swap = 1'b1; tick();
    w_swap = 1'b0; i_valid = 1'b1; tick();
    i_valid = 1'b0; tick();
    check("dbuf new shadow", p_out_d[0], 32'd50);

    // Output-stationary accumulate 4*(1+2+3), drain, forward two words.
    mode = 1'b1; acc_clear = 1'b1; w_valid = 1'b1; w_in = 8'd4; tick();
    acc_clear = 1'b0; w_valid = 1'b0; w_swap = 1'b1; tick();
    w_swap = 1'b0; i_valid = 1'b1; i_in = 16'd1; tick();
    i_in = 16'd2; tick();
    i_in = 16'd3; tick();
    i_valid = 1'b0; drain = 1'b1; tick();
    check("os no output while accumulating", p_v_d[0], 1'b0);
    tick();
    check("os drain own value", p_out_d[0], 32'd24);
    check("os drain own valid", p_v_d[0], 1'b1);
    p_in = 32'd11; p_valid_in = 1'b1; tick();
    check("os forward first", {p_v_d[0], p_out_d[0]}, {1'b1, 32'd11});
    p_in = 32'd12; drain = 1'b0; tick();
    check("os forward second", {p_v_d[0], p_out_d[0]}, {1'b1, 32'd12});
    p_valid_in = 1'b0; tick();
    check("os idle after drain", p_v_d[0], 1'b0);
    drain = 1'b1; tick();
    drain = 1'b0; tick();
    check("os acc zero after drain", {p_v_d[0], p_out_d[0]}, {1'b1, 32'd0});
    tick();

    // Reset while accumulating 77.
    w_valid = 1'b1; w_in = 8'd7; tick();
    w_valid = 1'b0; w_swap = 1'b1; tick();
    w_swap = 1'b0; i_valid = 1'b1; i_in = 16'd11; tick();
    i_valid = 1'b0; tick();
    rstn = 1'b0; i_valid = 1'b1; i_in = 16'h5A5A; w_valid = 1'b1; w_in = 8'h3C; p_valid_in = 1'b1;
    tick();
    check("midrst p_out", {p_v_d[0], p_out_d[0]}, 33'd0);
    check("midrst fwd", {i_v_d[0], i_out_d[0], w_v_d[0], w_out_d[0]}, 26'd0);
    check("midrst ovf", ovf_d[0], 1'b0);
    rstn = 1'b1; i_valid = 1'b0; i_in = '0; w_valid = 1'b0; w_in = '0; p_valid_in = 1'b0; p_in = '0;
    drain = 1'b1; tick();
    drain = 1'b0; tick();
    check("midrst acc discarded", {p_v_d[0], p_out_d[0]}, {1'b1, 32'd0});
    tick();

    // acc_clear together with a product: acc takes the product, ovf drops.
    mode = 1'b0;
    apply_row(1);
    mode = 1'b1; w_valid = 1'b1; w_in = 8'd1; tick();
    w_valid = 1'b0; w_swap = 1'b1; tick();
    w_swap = 1'b0; i_valid = 1'b1; i_in = 16'd9; tick();
    i_valid = 1'b0; acc_clear = 1'b1; tick();
    acc_clear = 1'b0;
    check("clear+prod ovf", ovf_d[0], 1'b0);
    drain = 1'b1; tick();
    drain = 1'b0; tick();
    check("clear+prod acc", {p_v_d[0], p_out_d[0]}, {1'b1, 32'd9});
    tick();

    for (int k = 0; k < 3; k++) cmp_model(k);

    for (int n = 0; n < 3000; n++) begin
      rstn       = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0)  drain = ~drain;
      i_valid    = $urandom_range(0, 1) == 1;
      i_in       = 16'($urandom);
      w_valid    = $urandom_range(0, 3) == 0;
      w_in       = 8'($urandom);
      w_swap     = $urandom_range(0, 7) == 0;
      p_valid_in = $urandom_range(0, 1) == 1;
      acc_clear  = $urandom_range(0, 39) == 0;
      case ($urandom_range(0, 3))
        0:       p_in = $urandom;
        1:       p_in = 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
        2:       p_in = 32'h8000_0000 | 32'($urandom_range(0, 255));
        default: p_in = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      endcase
      tick();
      for (int k = 0; k < 3; k++) cmp_model(k);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
